// File: rtl/ga_pkg.sv
// Shared parameters and the FSM state type for the GA mutation stage.
package ga_pkg;

    localparam int DATA_W      = 8;
    localparam int M_MAX       = 32;
    localparam int M_MAX_W     = 6;
    localparam int M_IDX_MAX_W = 5;
    localparam int CHROM_MAX_W = M_MAX * DATA_W;
    localparam int MUT_RATE_W  = 7;
    localparam int BIT_IDX_W   = 3;
    localparam int RAND_W      = MUT_RATE_W + BIT_IDX_W;

    // state  | meaning
    // IDLE   | waiting for a child chromosome from crossover
    // MUTATE | walking the active genes, one per clock
    // OUT    | mutated chromosome presented downstream, waiting for ack
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUTATE = 2'd1,
        OUT    = 2'd2
    } ga_state_e;

endpackage

// File: rtl/ga_mutation_gene_flip.sv
// Single-gene mutation: compares the rate field of the random word with the
// threshold and, on a hit, inverts the bit selected by the upper random bits.
module ga_mutation_gene_flip
    import ga_pkg::*;
(
    input  logic [DATA_W-1:0]     gene_i,
    input  logic [RAND_W-1:0]     rand_i,
    input  logic [MUT_RATE_W-1:0] rate_i,
    output logic [DATA_W-1:0]     gene_o,
    output logic                  hit_o
);

    logic [MUT_RATE_W-1:0] rate_field;
    logic [BIT_IDX_W-1:0]  bit_idx;

    assign rate_field = rand_i[MUT_RATE_W-1:0];
    assign bit_idx    = rand_i[RAND_W-1:MUT_RATE_W];

    // A threshold of 0 can never be exceeded, so rate 0 disables mutation.
    assign hit_o  = (rate_field < rate_i);
    assign gene_o = hit_o ? (gene_i ^ (DATA_W'(1) << bit_idx)) : gene_i;

endmodule

// File: rtl/ga_mutation.sv
// GA mutation stage: captures one child, mutates its active genes one per
// clock, then holds the result and mutation count until downstream acks.
module ga_mutation
    import ga_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   sw_rst,
    input  logic [M_MAX_W-1:0]     cnfg_m,
    input  logic [MUT_RATE_W-1:0]  cnfg_mut_rate,
    input  logic [RAND_W-1:0]      rand_data,
    input  logic                   child_valid,
    input  logic [CHROM_MAX_W-1:0] child,
    output logic                   child_ack,
    input  logic                   new_child_ack,
    output logic                   new_child_valid,
    output logic [CHROM_MAX_W-1:0] new_child,
    output logic [M_MAX_W-1:0]     mut_cnt
);

    ga_state_e              state_q, state_d;
    logic [CHROM_MAX_W-1:0] work_q, work_d;
    logic [M_IDX_MAX_W-1:0] idx_q, idx_d;
    logic [M_MAX_W-1:0]     cnt_q, cnt_d;
    logic [M_MAX_W-1:0]     meff_q, meff_d;
    logic                   ack_q, ack_d;
    logic                   valid_q, valid_d;

    logic [M_MAX_W-1:0]     cap_meff;
    logic [CHROM_MAX_W-1:0] child_masked;
    logic [DATA_W-1:0]      cur_gene;
    logic [DATA_W-1:0]      flip_gene;
    logic                   flip_hit;
    logic                   last_gene;

    assign cap_meff  = (cnfg_m > M_MAX_W'(M_MAX)) ? M_MAX_W'(M_MAX) : cnfg_m;
    assign cur_gene  = work_q[32'(idx_q)*DATA_W +: DATA_W];
    assign last_gene = ({1'b0, idx_q} == (meff_q - M_MAX_W'(1)));

    // Genes beyond the active count are cleared at capture.
    always_comb begin
        child_masked = '0;
        for (int g = 0; g < M_MAX; g++) begin
            if (g < int'(cap_meff)) begin
                child_masked[g*DATA_W +: DATA_W] = child[g*DATA_W +: DATA_W];
            end
        end
    end

    ga_mutation_gene_flip u_gene_flip (
        .gene_i (cur_gene),
        .rand_i (rand_data),
        .rate_i (cnfg_mut_rate),
        .gene_o (flip_gene),
        .hit_o  (flip_hit)
    );

    // Next-state and datapath updates; sw_rst overrides everything.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        meff_d  = meff_q;
        ack_d   = 1'b0;
        valid_d = valid_q;
        if (sw_rst) begin
            state_d = IDLE;
            work_d  = '0;
            idx_d   = '0;
            cnt_d   = '0;
            meff_d  = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (child_valid) begin
                        work_d = child_masked;
                        idx_d  = '0;
                        cnt_d  = '0;
                        meff_d = cap_meff;
                        ack_d  = 1'b1;
                        if (cap_meff != '0) begin
                            state_d = MUTATE;
                        end else begin
                            state_d = OUT;
                            valid_d = 1'b1;
                        end
                    end
                end
                MUTATE: begin
                    work_d[32'(idx_q)*DATA_W +: DATA_W] = flip_gene;
                    if (flip_hit && (cnt_q != M_MAX_W'(M_MAX))) begin
                        cnt_d = cnt_q + M_MAX_W'(1);
                    end
                    idx_d = idx_q + M_IDX_MAX_W'(1);
                    if (last_gene) begin
                        state_d = OUT;
                        valid_d = 1'b1;
                    end
                end
                OUT: begin
                    if (new_child_ack && valid_q) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            work_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            meff_q  <= '0;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            meff_q  <= meff_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
        end
    end

    assign child_ack       = ack_q;
    assign new_child_valid = valid_q;
    assign new_child       = work_q;
    assign mut_cnt         = cnt_q;

endmodule

// File: tb/tb_ga_mutation.sv
// Self-checking bench for ga_mutation: directed scenarios plus randomized
// chromosomes compared against a gene-by-gene arithmetic reference model.
module tb_ga_mutation;
    import ga_pkg::*;

    logic                   clk;
    logic                   rstn;
    logic                   sw_rst;
    logic [M_MAX_W-1:0]     cnfg_m;
    logic [MUT_RATE_W-1:0]  cnfg_mut_rate;
    logic [RAND_W-1:0]      rand_data;
    logic                   child_valid;
    logic [CHROM_MAX_W-1:0] child;
    logic                   child_ack;
    logic                   new_child_ack;
    logic                   new_child_valid;
    logic [CHROM_MAX_W-1:0] new_child;
    logic [M_MAX_W-1:0]     mut_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    logic [9:0] rnd [32];

    ga_mutation dut (
        .clk             (clk),
        .rstn            (rstn),
        .sw_rst          (sw_rst),
        .cnfg_m          (cnfg_m),
        .cnfg_mut_rate   (cnfg_mut_rate),
        .rand_data       (rand_data),
        .child_valid     (child_valid),
        .child           (child),
        .child_ack       (child_ack),
        .new_child_ack   (new_child_ack),
        .new_child_valid (new_child_valid),
        .new_child       (new_child),
        .mut_cnt         (mut_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [255:0] rand_chrom();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: for each active gene, mutate when (r mod 128) < rate by
    // flipping bit (r div 128); inactive genes read as zero.
    task automatic model(input logic [255:0] c, input int meff, input int rate,
                         output logic [255:0] o, output int cnt);
        logic [7:0] gene;
        o   = '0;
        cnt = 0;
        for (int g = 0; g < meff; g++) begin
            gene = c[g*8 +: 8];
            if (int'(rnd[g]) % 128 < rate) begin
                gene = gene ^ 8'(1 << (int'(rnd[g]) / 128));
                cnt++;
            end
            o[g*8 +: 8] = gene;
        end
    endtask

    // Called at a falling edge; presents a child, feeds random words, checks
    // latency and result, applies backpressure, then acks (or resets).
    task automatic run_txn(input logic [255:0] c, input logic [5:0] m, input logic [6:0] rate,
                           input bit fixed_r, input logic [9:0] rv, input int hold,
                           input bit pend, input bit fast, input bit arst);
        int w, meff, ecnt;
        logic [255:0] exp_c;
        child         = c;
        cnfg_m        = m;
        cnfg_mut_rate = rate;
        child_valid   = 1'b1;
        new_child_ack = 1'b0;
        meff = (int'(m) > 32) ? 32 : int'(m);
        w = 0;
        @(negedge clk);
        while (!child_ack && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!child_ack) begin
            check_val("ack_timeout", 0, 1);
            child_valid = 1'b0;
            return;
        end
        if (fast) check_val("fast_capture", w, 0);
        child_valid = 1'b0;
        cnfg_m      = 6'($urandom);
        child       = rand_chrom();
        if (meff == 0) check_val("valid_m0", new_child_valid, 1);
        for (int k = 0; k < meff; k++) begin
            check_val("valid_early", new_child_valid, 0);
            rnd[k]        = fixed_r ? rv : 10'($urandom);
            rand_data     = rnd[k];
            new_child_ack = 1'($urandom);
            @(negedge clk);
            if (k == 0) check_val("ack_pulse", child_ack, 0);
        end
        new_child_ack = 1'b0;
        rand_data     = 10'($urandom);
        check_val("valid_lat", new_child_valid, 1);
        model(c, meff, int'(rate), exp_c, ecnt);
        check_val("new_child", new_child, exp_c);
        check_val("mut_cnt", mut_cnt, ecnt);
        child_valid = pend;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_val("bp_valid", new_child_valid, 1);
            check_val("bp_ack", child_ack, 0);
            check_val("bp_data", new_child, exp_c);
            check_val("bp_cnt", mut_cnt, ecnt);
        end
        if (arst) begin
            child_valid = 1'b0;
            #2 rstn = 1'b0;
            #1 check_val("arst_out", {new_child_valid, child_ack, mut_cnt, new_child}, 0);
            @(negedge clk);
            rstn = 1'b1;
            return;
        end
        new_child_ack = 1'b1;
        @(negedge clk);
        new_child_ack = 1'b0;
        check_val("valid_drop", new_child_valid, 0);
        check_val("ack_in_drop", child_ack, 0);
    endtask

    initial begin
        bit pend, prev_pend;
        rstn          = 1'b0;
        sw_rst        = 1'b0;
        cnfg_m        = '0;
        cnfg_mut_rate = '0;
        rand_data     = '0;
        child_valid   = 1'b0;
        child         = '0;
        new_child_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_valid", new_child_valid, 0);
        check_val("rst_ack", child_ack, 0);
        check_val("rst_data", new_child, 0);
        check_val("rst_cnt", mut_cnt, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Zero rate: low four genes pass, the rest are cleared.
        run_txn({224'(rand_chrom()), 32'hA5A5A5A5}, 6'd4, 7'd0, 0, '0, 0, 0, 0, 0);
        // Always mutate: bit 3 of each active gene.
        run_txn('0, 6'd4, 7'd127, 1, 10'b011_0000000, 0, 0, 0, 0);
        // Rate 127 with rate field 127: never mutates.
        run_txn(rand_chrom(), 6'd5, 7'd127, 1, 10'b101_1111111, 0, 0, 0, 0);
        // Backpressure with a pending child, then immediate capture.
        run_txn(rand_chrom(), 6'd6, 7'd64, 0, '0, 10, 1, 0, 0);
        run_txn(rand_chrom(), 6'd5, 7'd30, 0, '0, 0, 0, 1, 0);
        // Zero and oversized gene counts.
        run_txn(rand_chrom(), 6'd0, 7'd100, 0, '0, 1, 0, 0, 0);
        run_txn(rand_chrom(), 6'd40, 7'd0, 0, '0, 0, 0, 0, 0);

        // Software reset in the middle of MUTATE.
        child         = rand_chrom();
        cnfg_m        = 6'd8;
        cnfg_mut_rate = 7'd127;
        rand_data     = 10'b000_0000000;
        child_valid   = 1'b1;
        @(negedge clk);
        check_val("sr_ack", child_ack, 1);
        child_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("sr_cnt_pre", mut_cnt, 2);
        sw_rst = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
        check_val("sr_clear", {new_child_valid, mut_cnt, new_child}, 0);
        run_txn(rand_chrom(), 6'd8, 7'd90, 0, '0, 0, 0, 1, 0);

        // Asynchronous reset while presenting the result.
        run_txn(rand_chrom(), 6'd3, 7'd50, 0, '0, 2, 0, 0, 1);
        run_txn(rand_chrom(), 6'd7, 7'd60, 0, '0, 0, 0, 0, 0);

        prev_pend = 1'b0;
        for (int t = 0; t < 25; t++) begin
            pend = 1'($urandom);
            run_txn(rand_chrom(), 6'($urandom_range(0, 40)), 7'($urandom),
                    0, '0, $urandom_range(0, 3), pend, prev_pend, 0);
            prev_pend = pend;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ga_mutation.md
Name: ga_mutation

Overview:
- GA pipeline stage directly downstream of ga_crossover.
- Accepts one child chromosome per valid/ack handshake and walks its active genes one gene per clock.
- Per gene, flips at most one bit, with probability set by cnfg_mut_rate.
- Presents the mutated chromosome and a mutation count to the population-update stage through a valid/ack handshake.

Parameters:
- DATA_W, 8, bits per gene.
- M_MAX, 32, maximum genes per chromosome.
- M_MAX_W, 6, width of gene-count values (holds M_MAX).
- M_IDX_MAX_W, 5, width of gene index.
- CHROM_MAX_W, M_MAX*DATA_W, flat chromosome width.
- MUT_RATE_W, 7, mutation-rate threshold width (resolution 1/128).
- BIT_IDX_W, 3, log2(DATA_W).
- RAND_W, MUT_RATE_W+BIT_IDX_W (10), random word width.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- sw_rst  in  1  synchronous software reset, active high
- cnfg_m  in  M_MAX_W  active gene count
- cnfg_mut_rate  in  MUT_RATE_W  per-gene mutation threshold
- rand_data  in  RAND_W  fresh random word every cycle
- child_valid  in  1  crossover child available
- child  in  CHROM_MAX_W  child chromosome; gene g at [(g+1)*DATA_W-1 : g*DATA_W]
- child_ack  out  1  one-cycle capture pulse
- new_child_ack  in  1  downstream consumed the output
- new_child_valid  out  1  mutated chromosome available
- new_child  out  CHROM_MAX_W  mutated chromosome
- mut_cnt  out  M_MAX_W  number of genes mutated in this chromosome

Behaviour:
- Reset: rstn low (async) or sw_rst high at a clock edge:
  - state goes to IDLE;
  - child_ack, new_child_valid, new_child, mut_cnt and the gene index all go to 0.
  - sw_rst takes priority over every other event, including mid-MUTATE and mid-OUT.
- Effective gene count m_eff is computed once, at capture:
  - m_eff = min(cnfg_m, M_MAX);
  - cnfg_m changes after capture do not affect the chromosome in flight.
- FSM states: IDLE, MUTATE, OUT.
- IDLE:
  - When child_valid=1 at edge 0, register child into the working register.
  - Genes with index >= m_eff are forced to 0.
  - Clear mut_cnt and the gene index.
  - child_ack=1 during cycle 0 only; it is registered, so it is never high two cycles in a row.
  - Next state is MUTATE if m_eff>0, else OUT.
- MUTATE: at edge k (k=1..m_eff), process gene k-1:
  - Gene k-1 mutates iff rand_data[MUT_RATE_W-1:0] < cnfg_mut_rate (unsigned).
  - On mutation, invert bit rand_data[RAND_W-1:MUT_RATE_W] of that gene and increment mut_cnt. mut_cnt is M_MAX_W wide and cannot wrap.
  - The gene index increments every edge.
  - At edge m_eff, go to OUT.
- Rate boundaries:
  - cnfg_mut_rate=0: no mutation ever.
  - cnfg_mut_rate=127: mutation unless the rate field equals 127.
- OUT:
  - new_child_valid=1 from cycle m_eff onward.
  - new_child and mut_cnt hold stable while valid is high.
  - On new_child_ack=1 at an edge: valid drops in the next cycle and state returns to IDLE.
  - A pending child_valid is not acked while in OUT (backpressure).
  - new_child_ack while valid=0 is ignored.
- Latency:
  - Capture edge to valid = m_eff cycles.
  - Throughput = one chromosome per m_eff+2 cycles with immediate ack.
- new_child is driven from the working register (no combinational path from child to new_child).

Decomposition:
- Shared include ga_params.const carries: DATA_W, M_MAX, M_MAX_W, M_IDX_MAX_W, CHROM_MAX_W, MUT_RATE_W, BIT_IDX_W.
- Package ga_pkg adds a state enum typedef (IDLE/MUTATE/OUT).
- One sub-module, ga_mutation_gene_flip: combinational, taking gene, rand_data and cnfg_mut_rate, producing the mutated gene and a hit flag.
  - Instantiated once.
  - Its input gene is selected by the gene index.

Test Plan:
- Zero rate: cnfg_m=4, cnfg_mut_rate=0, child low 32 bits 0xA5A5A5A5 (rest nonzero), capture at edge 0:
  - child_ack high cycle 0 only;
  - new_child_valid high cycle 4;
  - new_child = 0x...00A5A5A5A5 (genes 4..31 zero);
  - mut_cnt=0.
- Always-mutate: cnfg_m=4, rate=127, rand_data=10'b011_0000000 constant, child=0:
  - genes 0..3 = 0x08, genes 4..31 = 0;
  - mut_cnt=4.
- Backpressure: new_child_ack held low 10 cycles after valid while the next child_valid=1:
  - outputs stable;
  - no child_ack;
  - on ack, valid low next cycle;
  - next child captured one cycle later.
- cnfg_m=0: valid and child_ack both high in cycle 0; new_child=0; mut_cnt=0. cnfg_m=40: m_eff=32, valid at cycle 32, all genes pass through when rate=0.
- sw_rst pulsed in cycle 2 of MUTATE (cnfg_m=8):
  - next cycle valid=0, mut_cnt=0, new_child=0, IDLE;
  - a new child is then processed normally.
- rstn asserted asynchronously mid-OUT: outputs go to 0 without a clock edge.
